// File: rtl/gen_fifo_wptr_full_pkg.sv
// rtl/gen_fifo_wptr_full_pkg.sv - shared defaults and gray helper for FIFO pointer logic
package gen_fifo_wptr_full_pkg;

   localparam int FIFO_AW     = 4;
   localparam int SYNC_STAGES = 2;

   // Callers zero-extend into 32 bits and keep the low bits they need.
   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/gen_gray2binary.sv
// rtl/gen_gray2binary.sv - gray to binary decoder, prefix XOR from the MSB down
module gen_gray2binary #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   always_comb begin
      bin = '0;
      bin[WIDTH-1] = gray[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
   end

endmodule

// File: rtl/gen_fifo_wptr_full.sv
// rtl/gen_fifo_wptr_full.sv - write-side pointer, gray export and full/level status
module gen_fifo_wptr_full
   import gen_fifo_wptr_full_pkg::*;
#(
   parameter int ADDR_WIDTH   = FIFO_AW,
   parameter int SYNC_STAGES  = gen_fifo_wptr_full_pkg::SYNC_STAGES,
   parameter int AFULL_THRESH = 12
) (
   input  logic                  hclk,
   input  logic                  hresetn,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH:0]   rd_gray_async,
   output logic                  wr_en_ram,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [ADDR_WIDTH:0]   wr_gray,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   wr_level,
   output logic                  overflow
);

   localparam int AW = ADDR_WIDTH;
   localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_THRESH);

   logic [AW:0] wbin;
   logic [AW:0] wbin_next;
   logic [AW:0] gray_next;
   logic [AW:0] level_next;
   logic [AW:0] rq_gray;
   logic [AW:0] rq_bin;
   logic [AW:0] sync_q [SYNC_STAGES];
   logic [31:0] gray_wide;
   logic        full_next;
   logic        accept;

   genvar s;
   generate
      for (s = 0; s < SYNC_STAGES; s++) begin : g_sync
         always_ff @(posedge hclk) begin
            if (!hresetn) begin
               sync_q[s] <= '0;
            end else if (s == 0) begin
               sync_q[s] <= rd_gray_async;
            end else begin
               sync_q[s] <= sync_q[(s == 0) ? 0 : s-1];
            end
         end
      end
   endgenerate

   assign rq_gray = sync_q[SYNC_STAGES-1];

   gen_gray2binary #(
      .WIDTH(AW+1)
   ) u_rq_decode (
      .gray(rq_gray),
      .bin (rq_bin)
   );

   assign accept    = wr_req & ~full;
   assign wr_en_ram = accept;
   assign wr_addr   = wbin[AW-1:0];

   always_comb begin
      wbin_next  = wbin + {{AW{1'b0}}, accept};
      gray_wide  = bin2gray(32'(wbin_next));
      gray_next  = gray_wide[AW:0];
      // Full when the write pointer has lapped the read pointer by exactly one wrap.
      full_next  = (gray_next == {~rq_gray[AW:AW-1], rq_gray[AW-2:0]});
      level_next = wbin_next - rq_bin;
   end

   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         wbin        <= '0;
         wr_gray     <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         wr_level    <= '0;
         overflow    <= 1'b0;
      end else begin
         wbin        <= wbin_next;
         wr_gray     <= gray_next;
         full        <= full_next;
         almost_full <= (level_next >= AFULL_LVL);
         wr_level    <= level_next;
         overflow    <= wr_req & full;
      end
   end

endmodule

// File: tb/tb_gen_fifo_wptr_full.sv
// tb/tb_gen_fifo_wptr_full.sv - directed self-checking bench for gen_fifo_wptr_full
module tb_gen_fifo_wptr_full;

   logic       hclk = 1'b0;
   logic       hresetn;
   logic       wr_req;
   logic [4:0] rd_gray_async;
   logic       wr_en_ram;
   logic [3:0] wr_addr;
   logic [4:0] wr_gray;
   logic       full;
   logic       almost_full;
   logic [4:0] wr_level;
   logic       overflow;

   int n_checks = 0;
   int n_fail   = 0;

   gen_fifo_wptr_full #(
      .ADDR_WIDTH  (4),
      .SYNC_STAGES (2),
      .AFULL_THRESH(12)
   ) dut (
      .hclk         (hclk),
      .hresetn      (hresetn),
      .wr_req       (wr_req),
      .rd_gray_async(rd_gray_async),
      .wr_en_ram    (wr_en_ram),
      .wr_addr      (wr_addr),
      .wr_gray      (wr_gray),
      .full         (full),
      .almost_full  (almost_full),
      .wr_level     (wr_level),
      .overflow     (overflow)
   );

   always #5 hclk = ~hclk;

   function automatic logic [4:0] g(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge hclk);
      @(negedge hclk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] w;
      logic [4:0] prev_gray;

      // Reset with a push request pending
      hresetn = 1'b0;
      wr_req = 1'b1;
      rd_gray_async = 5'd0;
      tick();
      tick();
      check("rst_gray", wr_gray, 0);
      check("rst_addr", wr_addr, 0);
      check("rst_full", full, 0);
      check("rst_afull", almost_full, 0);
      check("rst_level", wr_level, 0);
      check("rst_ovf", overflow, 0);

      // Fill 16 entries with the reader parked at 0
      hresetn = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("fill_addr", wr_addr, i);
         check("fill_wen", wr_en_ram, 1);
         prev_gray = wr_gray;
         tick();
         check("fill_level", wr_level, i + 1);
         check("fill_afull", almost_full, (i + 1 >= 12) ? 1 : 0);
         check("fill_full", full, (i == 15) ? 1 : 0);
         check("fill_ham", $countones(prev_gray ^ wr_gray), 1);
      end
      check("fill_gray16", wr_gray, 5'b11000);
      check("fill_addr16", wr_addr, 0);

      // Push while full: dropped, overflow pulses each cycle
      for (int i = 0; i < 3; i++) begin
         check("ovf_wen", wr_en_ram, 0);
         tick();
         check("ovf_pulse", overflow, 1);
         check("ovf_gray", wr_gray, 5'b11000);
         check("ovf_full", full, 1);
      end
      wr_req = 1'b0;
      tick();
      check("ovf_clear", overflow, 0);

      // One read becomes visible three edges later
      rd_gray_async = 5'b00001;
      tick();
      check("drain_e1_full", full, 1);
      tick();
      check("drain_e2_full", full, 1);
      tick();
      check("drain_e3_full", full, 0);
      check("drain_e3_level", wr_level, 15);
      check("drain_e3_afull", almost_full, 1);

      // Reader jumps to 12, level settles to 4
      rd_gray_async = g(5'd12);
      tick();
      tick();
      tick();
      check("trail_level", wr_level, 4);
      check("trail_afull", almost_full, 0);

      // 40 pushes with the reader trailing, crossing the pointer wrap
      w = 5'd16;
      wr_req = 1'b1;
      for (int j = 0; j < 40; j++) begin
         rd_gray_async = g(w - 5'd4);
         prev_gray = wr_gray;
         tick();
         w = w + 5'd1;
         check("wrap_gray", wr_gray, g(w));
         check("wrap_ham", $countones(prev_gray ^ wr_gray), 1);
         check("wrap_full", full, 0);
         check("wrap_level", wr_level, (j == 0) ? 5 : (j == 1) ? 6 : 7);
         if (w == 5'd0) begin
            check("wrap_prev", prev_gray, 5'b10000);
            check("wrap_zero", wr_gray, 5'b00000);
         end
      end

      // Park at level 11 (write count 24, reader 13)
      wr_req = 1'b0;
      rd_gray_async = g(5'd13);
      tick();
      tick();
      tick();
      check("sim_pre_level", wr_level, 11);
      check("sim_pre_afull", almost_full, 0);

      // Push and read advance in the same cycle
      wr_req = 1'b1;
      rd_gray_async = g(5'd14);
      tick();
      wr_req = 1'b0;
      check("sim_e1_level", wr_level, 12);
      check("sim_e1_afull", almost_full, 1);
      tick();
      check("sim_e2_level", wr_level, 12);
      check("sim_e2_afull", almost_full, 1);
      tick();
      check("sim_e3_level", wr_level, 11);
      check("sim_e3_afull", almost_full, 0);
      check("sim_e3_addr", wr_addr, 9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
